axis_upsizer_pkt: RTL and testbench
===================================

# axis_upsizer_pkt

Packet-aware AXI4-Stream width upsizer that packs RATIO narrow input beats into one wide output beat, little-endian (first beat in lane 0). It flushes a partial wide word on tlast with a correct tkeep, and sustains one input beat per cycle under continuous output readiness. It sits between narrow producers (DMA/PHY side) and the wide datapath, and is the full-throughput, keep-aware successor to the existing upsizer.

## Interface
- S_WIDTH, 32, input data width in bits; multiple of 8.
- RATIO, 4, input beats per output beat; ≥1.
- M_WIDTH, S_WIDTH*RATIO, derived output width; not overridable.
- aclk  in  1  clock; all logic on rising edge.
- aresetn  in  1  reset, synchronous, active-low.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  input ready.
- s_axis_tdata  in  S_WIDTH  input data.
- s_axis_tkeep  in  S_WIDTH/8  input byte enables; copied verbatim into the lane's keep slice.
- s_axis_tlast  in  1  end of packet.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tready  in  1  output ready.
- m_axis_tdata  out  M_WIDTH  packed data; lane i = bits [i*S_WIDTH +: S_WIDTH].
- m_axis_tkeep  out  M_WIDTH/8  packed byte enables; unfilled lanes are 0.
- m_axis_tlast  out  1  last wide beat of packet.

## Operation
- Accumulator register (data, keep) plus lane counter `lane`, width max(1,$clog2(RATIO)), counts 0..RATIO-1.
- Output register (data, keep, last) with valid flag `m_axis_tvalid`.
- Input accept = s_axis_tvalid & s_axis_tready.
- On accept, the beat is written into lane `lane` of the working word.
- Completing beat: lane==RATIO-1 or s_axis_tlast=1.
  - Working word (accumulator merged with the current beat) loads into the output register in one step.
  - Lanes above `lane` carry data 0 and keep 0.
  - Output last is set to s_axis_tlast.
  - Accumulator keep and `lane` clear to 0.
- Non-completing beat: `lane` increments; output register untouched.
- Output register states:
  - EMPTY -> FULL on a completing accept.
  - FULL -> EMPTY on m_axis_tready with no completing accept.
  - FULL -> FULL (reload) on m_axis_tready with a completing accept in the same cycle.
  - FULL with m_axis_tready=0: holds data, keep and last stable.
- s_axis_tready = !m_axis_tvalid | m_axis_tready (combinational). Input stalls only while the output is full and not draining, even for non-completing beats.
- tlast on lane 0 yields a one-lane wide beat with last=1.
- RATIO=1: each accepted beat becomes one output beat; registered pass-through.
- Reset: all state cleared; partial accumulator content discarded.
- No tlast is ever invented; a packet that never sends tlast produces only full words.

## Timing
- Reset values: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tkeep=0. s_axis_tready=1 during and immediately after reset.
- Latency: output valid the cycle after the completing beat is accepted.
- Throughput: one input beat per cycle with m_axis_tready held high. Output rate is 1/RATIO for full words and higher with short packets.
- Back-to-back packets: no bubble between packets. The lane after a tlast beat is 0.
- Stable-under-backpressure: all m_axis_* outputs are constant while tvalid=1 and tready=0.
- Reset asserted mid-packet: outputs return to reset values on the next edge. The first post-reset beat goes to lane 0.

## Structure
- Shared package axis_pkg: lane_idx_t width function, and keep-width helper (width/8).
- One natural sub-module: axis_out_reg, the output holding register with the valid/ready handshake, reused by the planned downsizer.
- Accumulator and lane counter stay in the top level.

## Test plan
- Four beats 0x11111111..0x44444444, keep 0xF, tlast on the 4th, tready=1 -> one beat 0x44444444_33333333_22222222_11111111, keep 0xFFFF, last=1, one cycle after the 4th accept.
- Three beats (tlast on the 3rd, keep 0x3 on the 3rd) -> data lane 3 = 0, keep 0x03FF, last=1.
- Continuous 64 beats with tready=1 -> s_axis_tready never low, 16 output beats, no gaps.
- Output held with tready=0 for 10 cycles while input continues -> exactly 4 more beats accepted, then s_axis_tready=0; output stable; drain resumes without loss or duplication.
- Single-beat packet 0xDEADBEEF with tlast, followed immediately by a 4-beat packet -> beats (keep 0x000F, last=1) then (keep 0xFFFF, last=1), with the second packet starting in lane 0.
- aresetn low after 2 beats of a packet -> no output emitted; a following 4-beat packet emits exactly one correct word.

Source files
------------

// File: rtl/axis_pkg.sv
// Shared AXI4-Stream helpers: lane-index and keep-width sizing plus the
// holding-register state type used by the width converters.
package axis_pkg;

    // Bits needed to index RATIO lanes; never narrower than one bit.
    function automatic int lane_idx_w(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

    // Byte-enable width for a data bus of the given bit width.
    function automatic int keep_w(input int width);
        return width / 8;
    endfunction

    // Output holding register occupancy.
    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

endpackage

// File: rtl/axis_out_reg.sv
// Single-entry AXI4-Stream output holding register. Loads a complete word,
// presents it until the consumer takes it, and accepts a reload in the same
// cycle the current word drains. The occupancy state is exported on o_state.
module axis_out_reg
    import axis_pkg::*;
#(
    parameter int DATA_W = 128
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      i_load,
    input  logic [DATA_W-1:0]         i_data,
    input  logic [keep_w(DATA_W)-1:0] i_keep,
    input  logic                      i_last,
    input  logic                      i_ready,
    output logic                      o_valid,
    output logic [DATA_W-1:0]         o_data,
    output logic [keep_w(DATA_W)-1:0] o_keep,
    output logic                      o_last,
    output out_state_t                o_state
);

    localparam int KEEP_W = keep_w(DATA_W);

    out_state_t          r_state;
    logic                r_valid;
    logic [DATA_W-1:0]   r_data;
    logic [KEEP_W-1:0]   r_keep;
    logic                r_last;

    // Occupancy FSM with registered outputs; the caller only raises i_load
    // when the register is empty or draining this cycle.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state <= OUT_EMPTY;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_keep  <= '0;
            r_last  <= 1'b0;
        end else begin
            case (r_state)
                OUT_EMPTY: begin
                    if (i_load) begin
                        r_state <= OUT_FULL;
                        r_valid <= 1'b1;
                        r_data  <= i_data;
                        r_keep  <= i_keep;
                        r_last  <= i_last;
                    end
                end
                OUT_FULL: begin
                    if (i_ready) begin
                        if (i_load) begin
                            r_data <= i_data;
                            r_keep <= i_keep;
                            r_last <= i_last;
                        end else begin
                            r_state <= OUT_EMPTY;
                            r_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= OUT_EMPTY;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_keep  = r_keep;
    assign o_last  = r_last;
    assign o_state = r_state;

endmodule

// File: rtl/axis_upsizer_pkt.sv
// Packet-aware AXI4-Stream upsizer: packs RATIO narrow beats little-endian
// into one wide beat, flushing a partial word with zeroed upper lanes on tlast.
//
// Handshake: a beat transfers on a rising edge where tvalid and tready are
// both high; a source keeps tvalid and its payload stable until it transfers,
// and tready here never waits on tvalid.
module axis_upsizer_pkt
    import axis_pkg::*;
#(
    parameter int S_WIDTH = 32,
    parameter int RATIO   = 4
) (
    input  logic                               aclk,
    input  logic                               aresetn,
    input  logic                               s_axis_tvalid,
    output logic                               s_axis_tready,
    input  logic [S_WIDTH-1:0]                 s_axis_tdata,
    input  logic [keep_w(S_WIDTH)-1:0]         s_axis_tkeep,
    input  logic                               s_axis_tlast,
    output logic                               m_axis_tvalid,
    input  logic                               m_axis_tready,
    output logic [S_WIDTH*RATIO-1:0]           m_axis_tdata,
    output logic [keep_w(S_WIDTH*RATIO)-1:0]   m_axis_tkeep,
    output logic                               m_axis_tlast
);

    localparam int M_WIDTH = S_WIDTH * RATIO;
    localparam int S_KEEP  = keep_w(S_WIDTH);
    localparam int M_KEEP  = keep_w(M_WIDTH);
    localparam int LANE_W  = lane_idx_w(RATIO);

    logic [M_WIDTH-1:0] r_acc_data;
    logic [M_KEEP-1:0]  r_acc_keep;
    logic [LANE_W-1:0]  r_lane;

    logic               w_accept;
    logic               w_complete;
    logic               w_last_lane;
    logic [M_WIDTH-1:0] w_word_data;
    logic [M_KEEP-1:0]  w_word_keep;
    out_state_t         w_out_state;

    // Input stalls only while a wide word is held and not being taken.
    assign s_axis_tready = (w_out_state == OUT_EMPTY) || m_axis_tready;
    assign w_accept      = s_axis_tvalid && s_axis_tready;
    assign w_last_lane   = (r_lane == LANE_W'(RATIO - 1));
    assign w_complete    = w_accept && (w_last_lane || s_axis_tlast);

    // Working word: filled lanes from the accumulator, the live beat in the
    // current lane, and zero data/keep above it.
    always_comb begin
        w_word_data = '0;
        w_word_keep = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (LANE_W'(i) < r_lane) begin
                w_word_data[i*S_WIDTH +: S_WIDTH] = r_acc_data[i*S_WIDTH +: S_WIDTH];
                w_word_keep[i*S_KEEP  +: S_KEEP]  = r_acc_keep[i*S_KEEP  +: S_KEEP];
            end else if (LANE_W'(i) == r_lane) begin
                w_word_data[i*S_WIDTH +: S_WIDTH] = s_axis_tdata;
                w_word_keep[i*S_KEEP  +: S_KEEP]  = s_axis_tkeep;
            end
        end
    end

    // Accumulate non-completing beats; a completing beat restarts at lane 0.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_acc_data <= '0;
            r_acc_keep <= '0;
            r_lane     <= '0;
        end else if (w_accept) begin
            if (w_complete) begin
                r_acc_keep <= '0;
                r_lane     <= '0;
            end else begin
                for (int i = 0; i < RATIO; i++) begin
                    if (LANE_W'(i) == r_lane) begin
                        r_acc_data[i*S_WIDTH +: S_WIDTH] <= s_axis_tdata;
                        r_acc_keep[i*S_KEEP  +: S_KEEP]  <= s_axis_tkeep;
                    end
                end
                r_lane <= r_lane + LANE_W'(1);
            end
        end
    end

    axis_out_reg #(
        .DATA_W (M_WIDTH)
    ) u_out_reg (
        .aclk    (aclk),
        .aresetn (aresetn),
        .i_load  (w_complete),
        .i_data  (w_word_data),
        .i_keep  (w_word_keep),
        .i_last  (s_axis_tlast),
        .i_ready (m_axis_tready),
        .o_valid (m_axis_tvalid),
        .o_data  (m_axis_tdata),
        .o_keep  (m_axis_tkeep),
        .o_last  (m_axis_tlast),
        .o_state (w_out_state)
    );

endmodule

// File: tb/tb_axis_upsizer_pkt.sv
// Bench for axis_upsizer_pkt (S_WIDTH=32, RATIO=4): a per-cycle vector table
// for basic packing and flushing, then hand-written sequences for continuous
// streaming, backpressure and reset mid-packet, with an expected-word queue.
module tb_axis_upsizer_pkt;

    localparam int EW = 145;  // {last, keep[15:0], data[127:0]}

    logic         aclk;
    logic         aresetn;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic [31:0]  s_axis_tdata;
    logic [3:0]   s_axis_tkeep;
    logic         s_axis_tlast;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic [127:0] m_axis_tdata;
    logic [15:0]  m_axis_tkeep;
    logic         m_axis_tlast;

    int n_checks = 0;
    int n_fail   = 0;

    logic [EW-1:0] exp_q[$];
    bit  mon_en = 1'b0;
    int  out_cnt = 0;
    int  cyc = 0;
    int  first_out_cyc = 0;
    int  last_out_cyc = 0;

    axis_upsizer_pkt #(
        .S_WIDTH (32),
        .RATIO   (4)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast)
    );

    // ---------------- clock / reset ----------------
    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    always @(posedge aclk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic drive_idle();
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tlast  = 1'b0;
    endtask

    function automatic logic [EW-1:0] mk_word(input logic [31:0] base, input logic last);
        logic [127:0] d;
        for (int k = 0; k < 4; k++) d[k*32 +: 32] = base + 32'(k);
        return {last, 16'hFFFF, d};
    endfunction

    // Sends n beats base, base+1, ... with full keep; tlast on the final
    // beat when last_on_final. Bounded per beat.
    task automatic send_beats(input logic [31:0] base, input int n, input bit last_on_final,
                              output int last_acc_cyc);
        int i = 0;
        int guard = 0;
        last_acc_cyc = 0;
        while (i < n && guard < 1000) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = base + 32'(i);
            s_axis_tkeep  = 4'hF;
            s_axis_tlast  = last_on_final && (i == n - 1);
            @(negedge aclk);
            if (s_axis_tready) begin
                i++;
                last_acc_cyc = cyc;
            end
            tick();
            guard++;
        end
        if (i < n) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: accepted %0d beats, required %0d", i, n);
        end
        drive_idle();
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge aclk) begin
        if (mon_en && m_axis_tvalid && m_axis_tready) begin
            out_cnt++;
            if (out_cnt == 1) first_out_cyc = cyc;
            last_out_cyc = cyc;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got last=%b keep=%h data=%h, required no output",
                         m_axis_tlast, m_axis_tkeep, m_axis_tdata);
            end else begin
                chk("out_word", 160'({m_axis_tlast, m_axis_tkeep, m_axis_tdata}),
                    160'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic         v;
        logic [31:0]  d;
        logic [3:0]   k;
        logic         l;
        logic         mr;
        logic         e_sr;
        logic         e_mv;
        logic [127:0] e_md;
        logic [15:0]  e_mk;
        logic         e_ml;
    } vec_t;

    vec_t tbl[14];

    initial begin
        int stalls;
        int acc_cyc;
        int idx;
        int held_bad;
        int guard;

        // 4-beat packet, 3-beat packet with short keep, single-beat packet,
        // then a 4-beat packet that must start in lane 0.
        tbl[0]  = '{1'b1, 32'h11111111, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0, 128'h0, 16'h0, 1'b0};
        tbl[1]  = '{1'b1, 32'h22222222, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0, 128'h0, 16'h0, 1'b0};
        tbl[2]  = '{1'b1, 32'h33333333, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0, 128'h0, 16'h0, 1'b0};
        tbl[3]  = '{1'b1, 32'h44444444, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0, 128'h0, 16'h0, 1'b0};
        tbl[4]  = '{1'b1, 32'hAAAA0001, 4'hF, 1'b0, 1'b1, 1'b1, 1'b1,
                    128'h44444444_33333333_22222222_11111111, 16'hFFFF, 1'b1};
        tbl[5]  = '{1'b1, 32'hBBBB0002, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0, 128'h0, 16'h0, 1'b0};
        tbl[6]  = '{1'b1, 32'hCCCC0003, 4'h3, 1'b1, 1'b1, 1'b1, 1'b0, 128'h0, 16'h0, 1'b0};
        tbl[7]  = '{1'b1, 32'hDEADBEEF, 4'hF, 1'b1, 1'b1, 1'b1, 1'b1,
                    128'h00000000_CCCC0003_BBBB0002_AAAA0001, 16'h03FF, 1'b1};
        tbl[8]  = '{1'b1, 32'h50000001, 4'hF, 1'b0, 1'b1, 1'b1, 1'b1,
                    128'h00000000_00000000_00000000_DEADBEEF, 16'h000F, 1'b1};
        tbl[9]  = '{1'b1, 32'h50000002, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0, 128'h0, 16'h0, 1'b0};
        tbl[10] = '{1'b1, 32'h50000003, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0, 128'h0, 16'h0, 1'b0};
        tbl[11] = '{1'b1, 32'h50000004, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0, 128'h0, 16'h0, 1'b0};
        tbl[12] = '{1'b0, 32'h00000000, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1,
                    128'h50000004_50000003_50000002_50000001, 16'hFFFF, 1'b1};
        tbl[13] = '{1'b0, 32'h00000000, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 128'h0, 16'h0, 1'b0};

        // ---- reset ----
        drive_idle();
        m_axis_tready = 1'b1;
        aresetn = 1'b0;
        repeat (3) tick();
        @(negedge aclk);
        chk("rst_valid",  160'(m_axis_tvalid), 160'(0));
        chk("rst_data",   160'(m_axis_tdata),  160'(0));
        chk("rst_keep",   160'(m_axis_tkeep),  160'(0));
        chk("rst_last",   160'(m_axis_tlast),  160'(0));
        chk("rst_sready", 160'(s_axis_tready), 160'(1));
        tick();
        aresetn = 1'b1;

        // ---- table ----
        for (int i = 0; i < 14; i++) begin
            s_axis_tvalid = tbl[i].v;
            s_axis_tdata  = tbl[i].d;
            s_axis_tkeep  = tbl[i].k;
            s_axis_tlast  = tbl[i].l;
            m_axis_tready = tbl[i].mr;
            @(negedge aclk);
            chk($sformatf("vec%0d_sready", i), 160'(s_axis_tready), 160'(tbl[i].e_sr));
            chk($sformatf("vec%0d_mvalid", i), 160'(m_axis_tvalid), 160'(tbl[i].e_mv));
            if (tbl[i].e_mv) begin
                chk($sformatf("vec%0d_mdata", i), 160'(m_axis_tdata), 160'(tbl[i].e_md));
                chk($sformatf("vec%0d_mkeep", i), 160'(m_axis_tkeep), 160'(tbl[i].e_mk));
                chk($sformatf("vec%0d_mlast", i), 160'(m_axis_tlast), 160'(tbl[i].e_ml));
            end
            tick();
        end
        drive_idle();

        // ---- continuous 64 beats, tlast only on the last ----
        mon_en  = 1'b1;
        out_cnt = 0;
        for (int j = 0; j < 16; j++)
            exp_q.push_back(mk_word(32'hC0000000 + 32'(4*j), j == 15));
        stalls = 0;
        acc_cyc = 0;
        idx = 0;
        guard = 0;
        while (idx < 64 && guard < 200) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = 32'hC0000000 + 32'(idx);
            s_axis_tkeep  = 4'hF;
            s_axis_tlast  = (idx == 63);
            @(negedge aclk);
            if (s_axis_tready) begin
                idx++;
                acc_cyc = cyc;
            end else begin
                stalls++;
            end
            tick();
            guard++;
        end
        drive_idle();
        repeat (3) tick();
        chk("stream_accepted", 160'(idx), 160'(64));
        chk("stream_stalls",   160'(stalls), 160'(0));
        chk("stream_outcount", 160'(out_cnt), 160'(16));
        chk("stream_span",     160'(last_out_cyc - first_out_cyc), 160'(60));
        chk("stream_latency",  160'(last_out_cyc - acc_cyc), 160'(1));
        chk("stream_q_empty",  160'(exp_q.size()), 160'(0));

        // ---- backpressure: output held for 10 cycles ----
        out_cnt = 0;
        for (int j = 0; j < 3; j++)
            exp_q.push_back(mk_word(32'hB0000000 + 32'(4*j), j == 2));
        m_axis_tready = 1'b0;
        idx = 0;
        held_bad = 0;
        for (int c = 0; c < 10; c++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = 32'hB0000000 + 32'(idx);
            s_axis_tkeep  = 4'hF;
            s_axis_tlast  = (idx == 11);
            @(negedge aclk);
            if (c >= 5) begin
                if ({m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata} !==
                    {1'b1, mk_word(32'hB0000000, 1'b0)})
                    held_bad++;
            end
            if (s_axis_tready) idx++;
            tick();
        end
        @(negedge aclk);
        chk("bp_accepted",  160'(idx), 160'(4));
        chk("bp_sready",    160'(s_axis_tready), 160'(0));
        chk("bp_unstable",  160'(held_bad), 160'(0));
        chk("bp_held_word", 160'({m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata}),
            160'({1'b1, mk_word(32'hB0000000, 1'b0)}));
        tick();
        m_axis_tready = 1'b1;
        guard = 0;
        while (idx < 12 && guard < 100) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = 32'hB0000000 + 32'(idx);
            s_axis_tkeep  = 4'hF;
            s_axis_tlast  = (idx == 11);
            @(negedge aclk);
            if (s_axis_tready) idx++;
            tick();
            guard++;
        end
        drive_idle();
        repeat (3) tick();
        chk("bp_drain_accepted", 160'(idx), 160'(12));
        chk("bp_outcount",       160'(out_cnt), 160'(3));
        chk("bp_q_empty",        160'(exp_q.size()), 160'(0));

        // ---- reset mid-packet ----
        out_cnt = 0;
        send_beats(32'hE0000000, 2, 1'b0, acc_cyc);
        aresetn = 1'b0;
        repeat (2) tick();
        @(negedge aclk);
        chk("midrst_valid",  160'(m_axis_tvalid), 160'(0));
        chk("midrst_sready", 160'(s_axis_tready), 160'(1));
        tick();
        aresetn = 1'b1;
        exp_q.push_back(mk_word(32'hF0000000, 1'b1));
        send_beats(32'hF0000000, 4, 1'b1, acc_cyc);
        repeat (3) tick();
        chk("midrst_outcount", 160'(out_cnt), 160'(1));
        chk("midrst_q_empty",  160'(exp_q.size()), 160'(0));

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
